// File: rtl/sdemux_pkg.sv
// Shared constants and types for the sdemux frame demultiplexer.
// Holds the data width, beat count, FSM state encoding, the bank boundary
// indices for both routing modes, and the one-hot bank select codes.
package sdemux_pkg;

  localparam int unsigned DataWidth = 136;
  localparam int unsigned NumBeats  = 16;
  localparam int unsigned CntWidth  = 4;

  localparam logic [CntWidth-1:0] LastBeat = CntWidth'(NumBeats - 1);

  // First beat index routed to the next bank in each mode.
  localparam logic [CntWidth-1:0] Mode0Split  = CntWidth'(8);
  localparam logic [CntWidth-1:0] Mode1Split1 = CntWidth'(6);
  localparam logic [CntWidth-1:0] Mode1Split2 = CntWidth'(11);

  localparam logic [2:0] SelBank1 = 3'b001;
  localparam logic [2:0] SelBank2 = 3'b010;
  localparam logic [2:0] SelBank3 = 3'b100;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/sdemux_route.sv
// Combinational beat router for sdemux.
// Ports:
//   mux_flag  - latched routing mode of the current frame
//   scounter  - index of the beat being accepted
//   bank_sel  - one-hot bank select {bank3, bank2, bank1}
module sdemux_route
  import sdemux_pkg::*;
(
  input  logic                mux_flag,
  input  logic [CntWidth-1:0] scounter,
  output logic [2:0]          bank_sel
);

  always_comb begin
    bank_sel = SelBank1;
    if (!mux_flag) begin
      if (scounter >= Mode0Split) begin
        bank_sel = SelBank2;
      end
    end else begin
      if (scounter >= Mode1Split2) begin
        bank_sel = SelBank3;
      end else if (scounter >= Mode1Split1) begin
        bank_sel = SelBank2;
      end
    end
  end

endmodule

// File: rtl/sdemux.sv
// Frame demultiplexer: a start pulse opens a 16-beat frame; each accepted beat
// is XOR-accumulated into one of three banks selected by the beat index and
// the routing mode latched at start. Banks hold their value after the frame.
// Ports:
//   clk, rst             - clock, asynchronous active-high reset
//   start, mux_flag      - frame request and routing mode (sampled on start)
//   in_valid, data_in    - beat handshake and payload
//   in_ready             - high while a frame is running
//   data_out_1/2/3       - registered bank accumulators
//   scounter             - index of the next beat to accept
//   busy, done           - frame in progress; one-cycle completion pulse
module sdemux
  import sdemux_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 mux_flag,
  input  logic                 in_valid,
  input  logic [DataWidth-1:0] data_in,
  output logic                 in_ready,
  output logic [DataWidth-1:0] data_out_1,
  output logic [DataWidth-1:0] data_out_2,
  output logic [DataWidth-1:0] data_out_3,
  output logic [CntWidth-1:0]  scounter,
  output logic                 busy,
  output logic                 done
);

  state_e               state_q, state_d;
  logic                 mode_q;
  logic [CntWidth-1:0]  cnt_q;
  logic [DataWidth-1:0] bank1_q, bank2_q, bank3_q;
  logic [2:0]           bank_sel;
  logic                 frame_start;
  logic                 accept;

  sdemux_route u_route (
    .mux_flag (mode_q),
    .scounter (cnt_q),
    .bank_sel (bank_sel)
  );

  assign frame_start = (state_q == StIdle) && start;
  assign accept      = (state_q == StRun) && in_valid;

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StRun;
      end
      StRun: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && (cnt_q == LastBeat)) state_d = StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
      bank1_q <= '0;
      bank2_q <= '0;
      bank3_q <= '0;
    end else begin
      state_q <= state_d;
      if (frame_start) begin
        mode_q  <= mux_flag;
        cnt_q   <= '0;
        bank1_q <= '0;
        bank2_q <= '0;
        bank3_q <= '0;
      end else if (accept) begin
        // Counter wraps to 0 naturally after the last beat.
        cnt_q <= cnt_q + CntWidth'(1);
        unique case (bank_sel)
          SelBank1: bank1_q <= bank1_q ^ data_in;
          SelBank2: bank2_q <= bank2_q ^ data_in;
          SelBank3: bank3_q <= bank3_q ^ data_in;
          default:  ;
        endcase
      end
    end
  end

  assign data_out_1 = bank1_q;
  assign data_out_2 = bank2_q;
  assign data_out_3 = bank3_q;
  assign scounter   = cnt_q;

endmodule

// File: tb/tb_sdemux.sv
module tb_sdemux;
  import sdemux_pkg::*;

  logic         clk, rst, start, mux_flag, in_valid;
  logic [135:0] data_in;
  logic         in_ready, busy, done;
  logic [135:0] data_out_1, data_out_2, data_out_3;
  logic [3:0]   scounter;

  sdemux dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mux_flag   (mux_flag),
    .in_valid   (in_valid),
    .data_in    (data_in),
    .in_ready   (in_ready),
    .data_out_1 (data_out_1),
    .data_out_2 (data_out_2),
    .data_out_3 (data_out_3),
    .scounter   (scounter),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [135:0] PatA = 136'h0123456789abcdef0123456789abcdef;
  localparam logic [135:0] PatB = 136'hfedcba9876543210fedcba9876543210;
  localparam logic [135:0] PatC = 136'h0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f;

  typedef struct {
    string        name;
    logic         mode;
    int           kind;       // 0 all ones, 1 incrementing, 2 sparse, 3 random
    int           stall_at;
    int           stall_len;
    bit           poke;       // pulse start mid-frame at beat 4
    logic [135:0] e1, e2, e3;
  } vec_t;

  typedef struct packed {
    logic [135:0] e1, e2, e3;
  } exp_t;

  exp_t         sb[$];
  vec_t         vecs[7];
  logic [135:0] beats[16];
  logic [135:0] m1, m2, m3;
  int           n_tests = 0;
  int           n_fail  = 0;

  task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  function automatic logic [135:0] rnd136();
    return 136'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
  endfunction

  function automatic int bank_of(input logic mode, input int idx);
    if (!mode) return (idx <= 7) ? 1 : 2;
    if (idx <= 5) return 1;
    if (idx <= 10) return 2;
    return 3;
  endfunction

  task automatic fill_beats(input int kind);
    for (int i = 0; i < 16; i++) begin
      case (kind)
        0:       beats[i] = 136'h1;
        1:       beats[i] = 136'(i + 1);
        2:       beats[i] = (i == 0) ? PatA : (i == 6) ? PatB : (i == 15) ? PatC : '0;
        default: beats[i] = rnd136();
      endcase
    end
  endtask

  task automatic check_banks(input string tag);
    chk({tag, ".b1"}, data_out_1, m1);
    chk({tag, ".b2"}, data_out_2, m2);
    chk({tag, ".b3"}, data_out_3, m3);
  endtask

  // Entered and left at posedge+1 with the DUT idle.
  task automatic drive_frame(input logic mode, input int stall_at, input int stall_len,
                             input bit poke);
    exp_t e;
    start = 1'b1; mux_flag = mode; in_valid = 1'b1; data_in = rnd136();
    @(negedge clk);
    chk1("idle.ready", in_ready, 1'b0);
    chk1("idle.busy", busy, 1'b0);
    @(posedge clk); #1;
    start = 1'b0; mux_flag = ~mode;
    m1 = '0; m2 = '0; m3 = '0;
    for (int i = 0; i < 16; i++) begin
      if (i == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          in_valid = 1'b0; data_in = rnd136();
          @(negedge clk);
          chk("stall.cnt", 136'(scounter), 136'(i));
          chk1("stall.busy", busy, 1'b1);
          chk1("stall.done", done, 1'b0);
          check_banks("stall");
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1; data_in = beats[i];
      start = poke && (i == 4);
      if (i == 8) mux_flag = mode;
      @(negedge clk);
      chk("beat.cnt", 136'(scounter), 136'(i));
      chk1("beat.ready", in_ready, 1'b1);
      chk1("beat.busy", busy, 1'b1);
      chk1("beat.done", done, 1'b0);
      check_banks("beat");
      @(posedge clk); #1;
      start = 1'b0;
      case (bank_of(mode, i))
        1:       m1 ^= beats[i];
        2:       m2 ^= beats[i];
        default: m3 ^= beats[i];
      endcase
    end
    // DONE cycle: start and in_valid must both be ignored.
    start = 1'b1; in_valid = 1'b1; data_in = rnd136();
    @(negedge clk);
    chk1("done.done", done, 1'b1);
    chk1("done.busy", busy, 1'b0);
    chk1("done.ready", in_ready, 1'b0);
    chk("done.cnt", 136'(scounter), 136'(0));
    check_banks("done");
    if (sb.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL sb.empty: got no expected entry want one");
    end else begin
      e = sb.pop_front();
      chk("sb.b1", data_out_1, e.e1);
      chk("sb.b2", data_out_2, e.e2);
      chk("sb.b3", data_out_3, e.e3);
    end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk1("after.done", done, 1'b0);
    chk1("after.ready", in_ready, 1'b0);
    chk1("after.busy", busy, 1'b0);
    check_banks("hold");
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  function automatic vec_t mk(input string name, input logic mode, input int kind,
                              input int stall_at, input int stall_len, input bit poke,
                              input logic [135:0] e1, input logic [135:0] e2,
                              input logic [135:0] e3);
    vec_t v;
    v.name = name; v.mode = mode; v.kind = kind; v.stall_at = stall_at;
    v.stall_len = stall_len; v.poke = poke; v.e1 = e1; v.e2 = e2; v.e3 = e3;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    vecs[0] = mk("m0_ones", 1'b0, 0, -1, 0, 1'b0, '0, '0, '0);
    vecs[1] = mk("m0_inc", 1'b0, 1, -1, 0, 1'b0, 136'h8, 136'h18, '0);
    vecs[2] = mk("m1_sparse", 1'b1, 2, -1, 0, 1'b0, PatA, PatB, PatC);
    vecs[3] = mk("m1_inc", 1'b1, 1, -1, 0, 1'b0, 136'h7, 136'h7, 136'h10);
    vecs[4] = mk("m0_stall", 1'b0, 1, 5, 3, 1'b0, 136'h8, 136'h18, '0);
    vecs[5] = mk("m0_sparse", 1'b0, 2, -1, 0, 1'b0, PatA ^ PatB, PatC, '0);
    vecs[6] = mk("m1_poke", 1'b1, 2, -1, 0, 1'b1, PatA, PatB, PatC);

    rst = 1'b1; start = 1'b0; mux_flag = 1'b0; in_valid = 1'b0; data_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    m1 = '0; m2 = '0; m3 = '0;
    chk1("rst.ready", in_ready, 1'b0);
    chk1("rst.busy", busy, 1'b0);
    chk1("rst.done", done, 1'b0);
    chk("rst.cnt", 136'(scounter), 136'(0));
    check_banks("rst");
    @(posedge clk); #1;
    rst = 1'b0;

    // Beats offered in IDLE must be ignored.
    in_valid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      data_in = rnd136();
      @(negedge clk);
      chk1("idle_beat.ready", in_ready, 1'b0);
      check_banks("idle_beat");
      @(posedge clk); #1;
    end
    in_valid = 1'b0;

    for (int v = 0; v < 7; v++) begin
      fill_beats(vecs[v].kind);
      e.e1 = vecs[v].e1; e.e2 = vecs[v].e2; e.e3 = vecs[v].e3;
      sb.push_back(e);
      drive_frame(vecs[v].mode, vecs[v].stall_at, vecs[v].stall_len, vecs[v].poke);
    end

    for (int r = 0; r < 2; r++) begin
      logic md;
      md = r[0];
      fill_beats(3);
      e = '0;
      for (int i = 0; i < 16; i++) begin
        case (bank_of(md, i))
          1:       e.e1 ^= beats[i];
          2:       e.e2 ^= beats[i];
          default: e.e3 ^= beats[i];
        endcase
      end
      sb.push_back(e);
      drive_frame(md, -1, 0, 1'b0);
    end

    // Reset mid-frame at scounter=9.
    fill_beats(3);
    start = 1'b1; mux_flag = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; data_in = beats[i];
      @(posedge clk); #1;
    end
    chk("pre_rst.cnt", 136'(scounter), 136'(9));
    #2 rst = 1'b1;
    #1;
    m1 = '0; m2 = '0; m3 = '0;
    chk1("async_rst.ready", in_ready, 1'b0);
    chk1("async_rst.busy", busy, 1'b0);
    chk1("async_rst.done", done, 1'b0);
    chk("async_rst.cnt", 136'(scounter), 136'(0));
    check_banks("async_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      data_in = rnd136();
      @(negedge clk);
      chk1("post_rst.ready", in_ready, 1'b0);
      chk1("post_rst.done", done, 1'b0);
      check_banks("post_rst");
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    fill_beats(2);
    e.e1 = PatA; e.e2 = PatB; e.e3 = PatC;
    sb.push_back(e);
    drive_frame(1'b1, -1, 0, 1'b0);

    chk("sb.drained", 136'(sb.size()), 136'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
